// File: rtl/ysyx_25040111_ifu.sv
// ysyx_25040111_ifu: instruction fetch unit bridging the PC handshake to an AXI4-Lite read and the decoder.
module ysyx_25040111_ifu #(
  parameter logic [31:0] ERR_INST = 32'h00100073,
  parameter logic [15:0] TIMEOUT  = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        wb_done,
  output logic        fetch_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, HOLD, WAIT_WB} state_e;
  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d, inst_pc_q, inst_pc_d, araddr_q, araddr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d, drain_q, drain_d, pc_ready_q, pc_ready_d;
  logic        timeout;
  assign timeout = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1);
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    araddr_d   = araddr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pc_ready_d = 1'b0;
    // a response abandoned by timeout is swallowed by the first rvalid outside WAIT_R
    drain_d    = drain_q && !(rvalid && state_q != WAIT_R);
    case (state_q)
      IDLE: if (pc_valid) begin
        inst_pc_d = pc;
        if (pc[1:0] == 2'b00) begin
          araddr_d = pc;
          state_d  = REQ;
        end else begin
          inst_d  = ERR_INST;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      REQ: if (arready && !drain_q) begin
        cnt_d   = '0;
        state_d = WAIT_R;
      end
      WAIT_R: if (rvalid) begin
        inst_d  = (rresp == 2'b00) ? rdata : ERR_INST;
        err_d   = err_q || (rresp != 2'b00);
        state_d = HOLD;
      end else if (timeout) begin
        inst_d  = ERR_INST;
        err_d   = 1'b1;
        drain_d = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      HOLD: if (inst_ready) begin
        state_d    = wb_done ? IDLE : WAIT_WB;
        pc_ready_d = wb_done;
      end
      WAIT_WB: if (wb_done) begin
        state_d    = IDLE;
        pc_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      araddr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      drain_q    <= 1'b0;
      pc_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      araddr_q   <= araddr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
      pc_ready_q <= pc_ready_d;
    end
  end
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign araddr     = araddr_q;
  assign fetch_err  = err_q;
  assign pc_ready   = pc_ready_q;
  assign inst_valid = state_q == HOLD;
  assign arvalid    = state_q == REQ && !drain_q;
  assign rready     = state_q == WAIT_R || drain_q;
endmodule
